// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor-facing signal bundle for branch_resolve_queue.
// master = the pipeline side driving allocs and resolves; slave = the queue.
interface branch_resolve_queue_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [ADDR_WIDTH-1:0] alloc_idx;
  logic                  alloc_pred;
  logic [PC_WIDTH-1:0]   alloc_target;
  logic [PC_WIDTH-1:0]   alloc_fallthru;

  logic                  resolve_valid;
  logic                  resolve_taken;
  logic [PC_WIDTH-1:0]   resolve_target;

  logic                  update_valid;
  logic [ADDR_WIDTH-1:0] update_idx;
  logic                  actual_taken;
  logic                  flush;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic [CNT_W-1:0]      count;
  logic                  resolve_err;

  modport master (
    output alloc_valid, alloc_idx, alloc_pred, alloc_target, alloc_fallthru,
    output resolve_valid, resolve_taken, resolve_target,
    input  alloc_ready, update_valid, update_idx, actual_taken,
    input  flush, redirect_pc, count, resolve_err
  );

  modport slave (
    input  alloc_valid, alloc_idx, alloc_pred, alloc_target, alloc_fallthru,
    input  resolve_valid, resolve_taken, resolve_target,
    output alloc_ready, update_valid, update_idx, actual_taken,
    output flush, redirect_pc, count, resolve_err
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight predicted branches: checks each resolve against the
// stored prediction, trains the predictor, and raises a flush with redirect PC on mispredict.
module branch_resolve_queue #(
  parameter int ADDR_WIDTH = 8,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 4
) (
  input logic                   clk,
  input logic                   reset,
  branch_resolve_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] idx_q      [DEPTH];
  logic                  pred_q     [DEPTH];
  logic [PC_WIDTH-1:0]   target_q   [DEPTH];
  logic [PC_WIDTH-1:0]   fallthru_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic                  update_valid_q;
  logic [ADDR_WIDTH-1:0] update_idx_q;
  logic                  actual_taken_q;
  logic                  flush_q;
  logic [PC_WIDTH-1:0]   redirect_pc_q;
  logic                  resolve_err_q;

  logic                  full;
  logic                  empty;
  logic                  resolve_ok;
  logic                  mispredict;
  logic                  drop;
  logic                  alloc_ok;
  logic [ADDR_WIDTH-1:0] head_idx;
  logic                  head_pred;
  logic [PC_WIDTH-1:0]   head_target;
  logic [PC_WIDTH-1:0]   head_fallthru;

  assign head_idx      = idx_q[rd_ptr];
  assign head_pred     = pred_q[rd_ptr];
  assign head_target   = target_q[rd_ptr];
  assign head_fallthru = fallthru_q[rd_ptr];

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // The queue is already empty during the flush cycle; the flush term keeps that explicit.
  assign resolve_ok = bus.resolve_valid && !empty && !flush_q;
  assign mispredict = resolve_ok &&
                      ((head_pred != bus.resolve_taken) ||
                       (bus.resolve_taken && (head_target != bus.resolve_target)));
  assign drop       = mispredict || flush_q;
  // alloc_ready is based on the pre-pop occupancy, so a full queue never takes an alloc.
  assign alloc_ok   = bus.alloc_valid && !full && !drop;

  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      idx_q[wr_ptr]      <= bus.alloc_idx;
      pred_q[wr_ptr]     <= bus.alloc_pred;
      target_q[wr_ptr]   <= bus.alloc_target;
      fallthru_q[wr_ptr] <= bus.alloc_fallthru;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (mispredict) begin
      // Squash everything younger than the mispredicting branch.
      rd_ptr  <= rd_ptr + PTR_ONE;
      wr_ptr  <= rd_ptr + PTR_ONE;
      count_q <= '0;
    end else begin
      if (alloc_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (resolve_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({alloc_ok, resolve_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      update_valid_q <= 1'b0;
      update_idx_q   <= '0;
      actual_taken_q <= 1'b0;
      flush_q        <= 1'b0;
      redirect_pc_q  <= '0;
      resolve_err_q  <= 1'b0;
    end else begin
      update_valid_q <= resolve_ok;
      flush_q        <= mispredict;
      resolve_err_q  <= bus.resolve_valid && !resolve_ok;
      if (resolve_ok) begin
        update_idx_q   <= head_idx;
        actual_taken_q <= bus.resolve_taken;
      end
      if (mispredict) begin
        redirect_pc_q <= bus.resolve_taken ? bus.resolve_target : head_fallthru;
      end
    end
  end

  assign bus.alloc_ready  = !full;
  assign bus.update_valid = update_valid_q;
  assign bus.update_idx   = update_idx_q;
  assign bus.actual_taken = actual_taken_q;
  assign bus.flush        = flush_q;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.count        = count_q;
  assign bus.resolve_err  = resolve_err_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed vector bench for branch_resolve_queue: one row per clock, outputs
// compared just after the edge that consumed the row's inputs.
module tb_branch_resolve_queue;
  localparam int AW = 8;
  localparam int PW = 32;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.ADDR_WIDTH(AW), .PC_WIDTH(PW), .DEPTH(DP)) bif ();

  branch_resolve_queue #(.ADDR_WIDTH(AW), .PC_WIDTH(PW), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic          rst;
    logic          av;
    logic [AW-1:0] aidx;
    logic          apred;
    logic [PW-1:0] atgt;
    logic [PW-1:0] afall;
    logic          rv;
    logic          rtk;
    logic [PW-1:0] rtgt;
    logic          e_rdy;
    logic [2:0]    e_cnt;
    logic          e_uv;
    logic [AW-1:0] e_uidx;
    logic          e_at;
    logic          e_fl;
    logic [PW-1:0] e_rpc;
    logic          e_rerr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic rst, input logic av, input logic [AW-1:0] aidx, input logic apred,
    input logic [PW-1:0] atgt, input logic [PW-1:0] afall,
    input logic rv, input logic rtk, input logic [PW-1:0] rtgt,
    input logic e_rdy, input logic [2:0] e_cnt, input logic e_uv, input logic [AW-1:0] e_uidx,
    input logic e_at, input logic e_fl, input logic [PW-1:0] e_rpc, input logic e_rerr);
    vec_t v;
    v.rst = rst; v.av = av; v.aidx = aidx; v.apred = apred; v.atgt = atgt; v.afall = afall;
    v.rv = rv; v.rtk = rtk; v.rtgt = rtgt;
    v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_uv = e_uv; v.e_uidx = e_uidx; v.e_at = e_at;
    v.e_fl = e_fl; v.e_rpc = e_rpc; v.e_rerr = e_rerr;
    return v;
  endfunction

  // Shorthands: idle, alloc-only, resolve-only rows.
  function automatic vec_t idle(input logic [2:0] cnt);
    return mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, cnt != 3'd4, cnt, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t al(input logic [AW-1:0] idx, input logic pred, input logic [PW-1:0] tgt,
                              input logic [PW-1:0] fall, input logic [2:0] cnt);
    return mk(1, 1, idx, pred, tgt, fall, 0, 0, 0, cnt != 3'd4, cnt, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset              = v.rst;
    bif.alloc_valid    = v.av;
    bif.alloc_idx      = v.aidx;
    bif.alloc_pred     = v.apred;
    bif.alloc_target   = v.atgt;
    bif.alloc_fallthru = v.afall;
    bif.resolve_valid  = v.rv;
    bif.resolve_taken  = v.rtk;
    bif.resolve_target = v.rtgt;
    @(posedge clk);
    #1;
    chk({tag, " alloc_ready"},  32'(bif.alloc_ready),  32'(v.e_rdy));
    chk({tag, " count"},        32'(bif.count),        32'(v.e_cnt));
    chk({tag, " update_valid"}, 32'(bif.update_valid), 32'(v.e_uv));
    chk({tag, " flush"},        32'(bif.flush),        32'(v.e_fl));
    chk({tag, " resolve_err"},  32'(bif.resolve_err),  32'(v.e_rerr));
    if (v.e_uv || !v.rst) begin
      chk({tag, " update_idx"},   32'(bif.update_idx),   32'(v.e_uidx));
      chk({tag, " actual_taken"}, 32'(bif.actual_taken), 32'(v.e_at));
    end
    if (v.e_fl || !v.rst) begin
      chk({tag, " redirect_pc"},  bif.redirect_pc,       v.e_rpc);
    end
  endtask

  initial begin
    bif.alloc_valid = 0; bif.alloc_idx = 0; bif.alloc_pred = 0; bif.alloc_target = 0;
    bif.alloc_fallthru = 0; bif.resolve_valid = 0; bif.resolve_taken = 0; bif.resolve_target = 0;

    // Reset held two cycles
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // Correct not-taken prediction
    vecs.push_back(al(8'h12, 0, 32'h180, 32'h104, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 8'h12, 0, 0, 0, 0));
    // Direction mispredict with 3 queued, same-cycle alloc dropped
    vecs.push_back(al(8'h05, 0, 32'h280, 32'h208, 1));
    vecs.push_back(al(8'h06, 1, 32'h500, 32'h30C, 2));
    vecs.push_back(al(8'h07, 0, 32'h580, 32'h310, 3));
    vecs.push_back(mk(1, 1, 8'h08, 0, 0, 32'h314, 1, 1, 32'h300, 1, 0, 1, 8'h05, 1, 1, 32'h300, 0));
    // Flush cycle: alloc dropped, resolve rejected
    vecs.push_back(mk(1, 1, 8'h09, 0, 0, 32'h318, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(idle(0));
    // Target mismatch
    vecs.push_back(al(8'h20, 1, 32'h400, 32'h40C, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 32'h480, 1, 0, 1, 8'h20, 1, 1, 32'h480, 0));
    vecs.push_back(idle(0));
    // Correct taken prediction
    vecs.push_back(al(8'h21, 1, 32'h600, 32'h60C, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 32'h600, 1, 0, 1, 8'h21, 1, 0, 0, 0));
    // Predicted taken, actually not taken -> fallthrough
    vecs.push_back(al(8'h22, 1, 32'h700, 32'h70C, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 32'h700, 1, 0, 1, 8'h22, 0, 1, 32'h70C, 0));
    vecs.push_back(idle(0));
    // Fill, full-queue rejects, FIFO order across wrap
    vecs.push_back(al(8'h31, 0, 0, 32'h1004, 1));
    vecs.push_back(al(8'h32, 0, 0, 32'h1008, 2));
    vecs.push_back(al(8'h33, 0, 0, 32'h100C, 3));
    vecs.push_back(al(8'h34, 0, 0, 32'h1010, 4));
    vecs.push_back(al(8'h3F, 0, 0, 32'h1014, 4));
    vecs.push_back(mk(1, 1, 8'h35, 0, 0, 32'h1018, 1, 0, 0, 1, 3, 1, 8'h31, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h36, 0, 0, 32'h101C, 1, 0, 0, 1, 3, 1, 8'h32, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 1, 8'h33, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 8'h34, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 8'h36, 0, 0, 0, 0));
    // Empty resolve
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(idle(0));
    // Reset with 3 queued (a resolve during reset is ignored)
    vecs.push_back(al(8'h41, 0, 0, 32'h2004, 1));
    vecs.push_back(al(8'h42, 0, 0, 32'h2008, 2));
    vecs.push_back(al(8'h43, 0, 0, 32'h200C, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h999, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle(0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    // Alloc + resolve while empty: alloc taken, resolve rejected
    vecs.push_back(mk(1, 1, 8'h50, 0, 32'h880, 32'h804, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 8'h50, 0, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back resolves over a full queue; the third mispredicts on target,
    // squashing the fourth, which then lands in the flush cycle as an empty resolve.
    apply(al(8'h60, 0, 32'hA00, 32'h904, 1), "seq alloc60");
    apply(al(8'h61, 0, 32'hA00, 32'h908, 2), "seq alloc61");
    apply(al(8'h62, 1, 32'h900, 32'h90C, 3), "seq alloc62");
    apply(al(8'h63, 0, 32'hA00, 32'h910, 4), "seq alloc63");
    apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 1, 8'h60, 0, 0, 0, 0), "seq res60");
    apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 1, 8'h61, 0, 0, 0, 0), "seq res61");
    apply(mk(1, 0, 0, 0, 0, 0, 1, 1, 32'h904, 1, 0, 1, 8'h62, 1, 1, 32'h904, 0), "seq res62");
    apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), "seq res63");
    apply(idle(0), "seq idle");
    // Queue usable again after the squash
    apply(al(8'h70, 0, 32'hB00, 32'hB04, 1), "seq alloc70");
    apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 8'h70, 0, 0, 0, 0), "seq res70");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
